// File: rtl/arya_pkg.sv
// ============================================================================
//  Module   : arya_pkg
//  Purpose  : Shared definitions for the Arya execute-stage result buffer:
//             default datapath/register-index widths, buffer occupancy
//             state encoding and the packed buffer entry layout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arya_pkg;

  localparam int DEFAULT_DATAPATH_WIDTH = 64;
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;

  // Buffer occupancy: main entry only in ONE, main + skid in FULL.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  // Entry layout, MSB first. The top module packs its flat entry vectors
  // in the same field order.
  typedef struct packed {
    logic [DEFAULT_DATAPATH_WIDTH-1:0] accum;
    logic                              zero;
    logic [DEFAULT_REG_ADDR_WIDTH-1:0] rd_addr;
    logic                              wr_en;
  } ex_entry_t;

endpackage

`default_nettype wire

// File: rtl/ex_buf_entry.sv
// ============================================================================
//  Module   : ex_buf_entry
//  Purpose  : Single load-enabled storage entry with asynchronous reset to
//             zero. Used for both the main (head) and skid entries of
//             ex_result_buffer.
//  Ports    : clk      - clock, rising edge
//             rst_n    - asynchronous active-low reset (clears entry)
//             load_in  - capture d_in on the next rising edge
//             d_in     - entry data to capture
//             q_out    - stored entry
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_buf_entry
  import arya_pkg::*;
#(
  parameter int W = $bits(ex_entry_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_in,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_in) begin
      data_d = d_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_out = data_q;

endmodule

`default_nettype wire

// File: rtl/ex_result_buffer.sv
// ============================================================================
//  Module   : ex_result_buffer
//  Purpose  : Two-entry elastic buffer between the ALU (execute) and the
//             memory/writeback stage. Valid/ready on both sides, absorbs a
//             one-cycle downstream stall, one result per cycle unstalled.
//  Ports    : clk, rst_n (async active-low), flush_in (sync discard)
//             upstream   : valid_in, ready_out, accum_in, zero_in,
//                          rd_addr_in, wr_en_in
//             downstream : valid_out, ready_in, accum_out, zero_out,
//                          rd_addr_out, wr_en_out
//             forwarding : fwd_valid_out, fwd_addr_out, fwd_data_out
//  Config   : EX_BUF_FORWARD_EN - when defined, adds the fwd_* ports that
//             present the youngest buffered entry for operand forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_result_buffer
  import arya_pkg::*;
#(
  parameter int DATAPATH_WIDTH = DEFAULT_DATAPATH_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [DATAPATH_WIDTH-1:0] accum_in,
  input  logic                      zero_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
  input  logic                      wr_en_in,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [DATAPATH_WIDTH-1:0] accum_out,
  output logic                      zero_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_out,
  output logic                      wr_en_out
`ifdef EX_BUF_FORWARD_EN
  ,
  output logic                      fwd_valid_out,
  output logic [REG_ADDR_WIDTH-1:0] fwd_addr_out,
  output logic [DATAPATH_WIDTH-1:0] fwd_data_out
`endif
);

  // Flat entry: {accum, zero, rd_addr, wr_en}, same order as ex_entry_t.
  localparam int ENTRY_W = DATAPATH_WIDTH + REG_ADDR_WIDTH + 2;

  buf_state_e         state_q;
  buf_state_e         state_d;

  logic               up_xfer;
  logic               dn_xfer;
  logic               main_load;
  logic               main_from_skid;
  logic               skid_load;

  logic [ENTRY_W-1:0] cap_entry;
  logic [ENTRY_W-1:0] main_din;
  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] skid_q;

  // Handshake flags come only from registered state, never from ready_in.
  assign ready_out = (state_q != FULL);
  assign valid_out = (state_q != EMPTY);
  assign up_xfer   = valid_in & ready_out;
  assign dn_xfer   = valid_out & ready_in;

  // Register 0 is hard-wired, so a write to it is squashed at capture.
  assign cap_entry = {accum_in, zero_in, rd_addr_in,
                      wr_en_in & (rd_addr_in != '0)};
  assign main_din  = main_from_skid ? skid_q : cap_entry;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush_in) begin
      // Flush wins over any transfer; entry contents become don't-care.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (up_xfer) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (up_xfer && dn_xfer) begin
            main_load = 1'b1;
          end else if (up_xfer) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (dn_xfer) begin
            state_d   = EMPTY;
          end
        end
        FULL: begin
          if (dn_xfer) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  ex_buf_entry #(
    .W (ENTRY_W)
  ) u_main_entry (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_in (main_load),
    .d_in    (main_din),
    .q_out   (main_q)
  );

  ex_buf_entry #(
    .W (ENTRY_W)
  ) u_skid_entry (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_in (skid_load),
    .d_in    (cap_entry),
    .q_out   (skid_q)
  );

  assign accum_out   = main_q[ENTRY_W-1 -: DATAPATH_WIDTH];
  assign zero_out    = main_q[REG_ADDR_WIDTH+1];
  assign rd_addr_out = main_q[REG_ADDR_WIDTH:1];
  assign wr_en_out   = main_q[0];

`ifdef EX_BUF_FORWARD_EN
  // Youngest valid entry: skid when FULL, otherwise main.
  logic [ENTRY_W-1:0] young_entry;

  always_comb begin
    young_entry = main_q;
    if (state_q == FULL) begin
      young_entry = skid_q;
    end
  end

  assign fwd_valid_out = (state_q != EMPTY) & young_entry[0];
  assign fwd_addr_out  = young_entry[REG_ADDR_WIDTH:1];
  assign fwd_data_out  = young_entry[ENTRY_W-1 -: DATAPATH_WIDTH];
`endif

endmodule

`default_nettype wire
